// File: rtl/uart_core_cfg_pkg.sv
// Shared definitions for the configurable UART core: FSM state encoding and oversampling rate.
package uart_core_cfg_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned HALF_BIT   = OVERSAMPLE / 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; a read alongside a write lets a full FIFO
// accept the write.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic [AW:0]      o_level
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW:0] FullCount = (AW + 1)'(Depth);

  logic [WIDTH-1:0] r_mem [Depth];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FullCount);
  assign o_level = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_rd_en = i_rd & ~o_empty;
  assign w_wr_en = i_wr & (~o_full | w_rd_en);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; contents are only observed when non-empty.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_core_cfg.sv
// UART core with runtime parity/stop modes: baud tick generator, RX/TX FSMs and two FIFOs.
// RX FIFO words carry {frame_err, parity_err, data}.
module uart_core_cfg
  import uart_core_cfg_pkg::*;
#(
  parameter int unsigned DBIT     = 8,
  parameter int unsigned SB_TICK  = 16,
  parameter int unsigned FIFO_AW  = 4,
  parameter int unsigned DIV_BITS = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIV_BITS-1:0] baud_div,
  input  logic                parity_en,
  input  logic                parity_odd,
  input  logic                stop2,
  input  logic                rx,
  output logic [DBIT-1:0]     r_data,
  output logic                rx_parity_err,
  output logic                rx_frame_err,
  input  logic                rd_uart,
  output logic                rx_empty,
  output logic [FIFO_AW:0]    rx_level,
  output logic                rx_overrun,
  input  logic                clr_overrun,
  input  logic [DBIT-1:0]     w_data,
  input  logic                wr_uart,
  output logic                tx_full,
  output logic [FIFO_AW:0]    tx_level,
  output logic                tx,
  output logic                tx_busy
);

  localparam int unsigned TickW = ($clog2(2 * SB_TICK) > 4) ? $clog2(2 * SB_TICK) : 4;
  localparam int unsigned BitW  = $clog2(DBIT + 1);
  localparam logic [TickW-1:0] BitLast   = TickW'(OVERSAMPLE - 1);
  localparam logic [TickW-1:0] HalfLast  = TickW'(HALF_BIT - 1);
  localparam logic [TickW-1:0] Stop1Last = TickW'(SB_TICK - 1);
  localparam logic [TickW-1:0] Stop2Last = TickW'(2 * SB_TICK - 1);
  localparam logic [BitW-1:0]  DataLast  = BitW'(DBIT - 1);

  // Baud tick; >= keeps the counter sane if baud_div is lowered mid-count.
  logic [DIV_BITS-1:0] r_tick_cnt;
  logic                w_tick;

  assign w_tick = (r_tick_cnt >= baud_div);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + 1'b1;
  end

  logic r_rx_meta;
  logic r_rx_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receiver
  uart_state_e      r_rx_state;
  logic [TickW-1:0] r_rx_s;
  logic [BitW-1:0]  r_rx_n;
  logic [DBIT-1:0]  r_rx_shift;
  logic             r_rx_par_en;
  logic             r_rx_odd;
  logic             r_rx_stop2;
  logic             r_rx_par_err;
  logic             r_rx_push;
  logic [DBIT+1:0]  r_rx_word;
  logic [TickW-1:0] w_rx_stop_last;

  assign w_rx_stop_last = r_rx_stop2 ? Stop2Last : Stop1Last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state   <= StIdle;
      r_rx_s       <= '0;
      r_rx_n       <= '0;
      r_rx_shift   <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_odd     <= 1'b0;
      r_rx_stop2   <= 1'b0;
      r_rx_par_err <= 1'b0;
      r_rx_push    <= 1'b0;
      r_rx_word    <= '0;
    end else begin
      r_rx_push <= 1'b0;
      case (r_rx_state)
        StIdle: begin
          if (!r_rx_sync) begin
            r_rx_state <= StStart;
            r_rx_s     <= '0;
          end
        end
        StStart: begin
          if (w_tick) begin
            if (r_rx_s == HalfLast) begin
              r_rx_s <= '0;
              if (!r_rx_sync) begin
                r_rx_state   <= StData;
                r_rx_n       <= '0;
                r_rx_par_en  <= parity_en;
                r_rx_odd     <= parity_odd;
                r_rx_stop2   <= stop2;
                r_rx_par_err <= 1'b0;
              end else begin
                r_rx_state <= StIdle;
              end
            end else begin
              r_rx_s <= r_rx_s + 1'b1;
            end
          end
        end
        StData: begin
          if (w_tick) begin
            if (r_rx_s == BitLast) begin
              r_rx_s     <= '0;
              r_rx_shift <= {r_rx_sync, r_rx_shift[DBIT-1:1]};
              if (r_rx_n == DataLast) r_rx_state <= r_rx_par_en ? StParity : StStop;
              else                    r_rx_n <= r_rx_n + 1'b1;
            end else begin
              r_rx_s <= r_rx_s + 1'b1;
            end
          end
        end
        StParity: begin
          if (w_tick) begin
            if (r_rx_s == BitLast) begin
              r_rx_s       <= '0;
              r_rx_par_err <= r_rx_sync ^ (^r_rx_shift) ^ r_rx_odd;
              r_rx_state   <= StStop;
            end else begin
              r_rx_s <= r_rx_s + 1'b1;
            end
          end
        end
        StStop: begin
          if (w_tick) begin
            if (r_rx_s == w_rx_stop_last) begin
              r_rx_push  <= 1'b1;
              r_rx_word  <= {~r_rx_sync, r_rx_par_err, r_rx_shift};
              r_rx_state <= StIdle;
            end else begin
              r_rx_s <= r_rx_s + 1'b1;
            end
          end
        end
        default: r_rx_state <= StIdle;
      endcase
    end
  end

  logic [DBIT+1:0] w_rx_head;
  logic            w_rx_empty;
  logic            w_rx_full;

  uart_sync_fifo #(
    .WIDTH (DBIT + 2),
    .AW    (FIFO_AW)
  ) u_rx_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_wr    (r_rx_push),
    .i_wdata (r_rx_word),
    .i_rd    (rd_uart),
    .o_rdata (w_rx_head),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full),
    .o_level (rx_level)
  );

  assign rx_empty      = w_rx_empty;
  assign r_data        = w_rx_head[DBIT-1:0];
  assign rx_parity_err = w_rx_head[DBIT] & ~w_rx_empty;
  assign rx_frame_err  = w_rx_head[DBIT+1] & ~w_rx_empty;

  // A full FIFO still accepts the push when the same cycle pops.
  logic r_overrun;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                r_overrun <= 1'b0;
    else if (clr_overrun)                      r_overrun <= 1'b0;
    else if (r_rx_push & w_rx_full & ~rd_uart) r_overrun <= 1'b1;
  end

  assign rx_overrun = r_overrun;

  // Transmitter
  logic [DBIT-1:0] w_tx_head;
  logic            w_tx_empty;
  logic            w_tx_pop;

  uart_state_e      r_tx_state;
  logic [TickW-1:0] r_tx_s;
  logic [BitW-1:0]  r_tx_n;
  logic [DBIT-1:0]  r_tx_shift;
  logic             r_tx_par;
  logic             r_tx_par_en;
  logic             r_tx_stop2;
  logic             r_tx;
  logic             r_tx_busy;
  logic [TickW-1:0] w_tx_stop_last;

  assign w_tx_pop       = (r_tx_state == StIdle) & w_tick & ~w_tx_empty;
  assign w_tx_stop_last = r_tx_stop2 ? Stop2Last : Stop1Last;

  uart_sync_fifo #(
    .WIDTH (DBIT),
    .AW    (FIFO_AW)
  ) u_tx_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_wr    (wr_uart),
    .i_wdata (w_data),
    .i_rd    (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (tx_full),
    .o_level (tx_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state  <= StIdle;
      r_tx_s      <= '0;
      r_tx_n      <= '0;
      r_tx_shift  <= '0;
      r_tx_par    <= 1'b0;
      r_tx_par_en <= 1'b0;
      r_tx_stop2  <= 1'b0;
      r_tx        <= 1'b1;
      r_tx_busy   <= 1'b0;
    end else begin
      case (r_tx_state)
        StIdle: begin
          if (w_tx_pop) begin
            r_tx_state  <= StStart;
            r_tx_s      <= '0;
            r_tx_shift  <= w_tx_head;
            r_tx_par    <= (^w_tx_head) ^ parity_odd;
            r_tx_par_en <= parity_en;
            r_tx_stop2  <= stop2;
            r_tx        <= 1'b0;
            r_tx_busy   <= 1'b1;
          end
        end
        StStart: begin
          if (w_tick) begin
            if (r_tx_s == BitLast) begin
              r_tx_s     <= '0;
              r_tx_n     <= '0;
              r_tx_state <= StData;
              r_tx       <= r_tx_shift[0];
            end else begin
              r_tx_s <= r_tx_s + 1'b1;
            end
          end
        end
        StData: begin
          if (w_tick) begin
            if (r_tx_s == BitLast) begin
              r_tx_s <= '0;
              if (r_tx_n == DataLast) begin
                r_tx_state <= r_tx_par_en ? StParity : StStop;
                r_tx       <= r_tx_par_en ? r_tx_par : 1'b1;
              end else begin
                r_tx_n     <= r_tx_n + 1'b1;
                r_tx_shift <= {1'b0, r_tx_shift[DBIT-1:1]};
                r_tx       <= r_tx_shift[1];
              end
            end else begin
              r_tx_s <= r_tx_s + 1'b1;
            end
          end
        end
        StParity: begin
          if (w_tick) begin
            if (r_tx_s == BitLast) begin
              r_tx_s     <= '0;
              r_tx_state <= StStop;
              r_tx       <= 1'b1;
            end else begin
              r_tx_s <= r_tx_s + 1'b1;
            end
          end
        end
        StStop: begin
          if (w_tick) begin
            if (r_tx_s == w_tx_stop_last) begin
              r_tx_state <= StIdle;
              r_tx_busy  <= 1'b0;
            end else begin
              r_tx_s <= r_tx_s + 1'b1;
            end
          end
        end
        default: begin
          r_tx_state <= StIdle;
          r_tx       <= 1'b1;
          r_tx_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_tx_busy;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Randomised scoreboard bench for uart_core_cfg: serial frames are modelled bit by bit and the
// expected RX FIFO words are queued at stimulus time and checked by an independent monitor.
module tb_uart_core_cfg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] baud_div = '0;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        stop2 = 1'b0;
  logic        rx_drv = 1'b1;
  logic        lb_en = 1'b0;
  logic        w_rx;
  logic [7:0]  r_data;
  logic        rx_parity_err;
  logic        rx_frame_err;
  logic        rd_uart = 1'b0;
  logic        rx_empty;
  logic [4:0]  rx_level;
  logic        rx_overrun;
  logic        clr_overrun = 1'b0;
  logic [7:0]  w_data = '0;
  logic        wr_uart = 1'b0;
  logic        tx_full;
  logic [4:0]  tx_level;
  logic        tx;
  logic        tx_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [9:0] exp_q[$];
  logic       mon_en = 1'b1;

  assign w_rx = lb_en ? tx : rx_drv;

  always #5 clk = ~clk;

  uart_core_cfg dut (
    .clk           (clk),
    .reset         (reset),
    .baud_div      (baud_div),
    .parity_en     (parity_en),
    .parity_odd    (parity_odd),
    .stop2         (stop2),
    .rx            (w_rx),
    .r_data        (r_data),
    .rx_parity_err (rx_parity_err),
    .rx_frame_err  (rx_frame_err),
    .rd_uart       (rd_uart),
    .rx_empty      (rx_empty),
    .rx_level      (rx_level),
    .rx_overrun    (rx_overrun),
    .clr_overrun   (clr_overrun),
    .w_data        (w_data),
    .wr_uart       (wr_uart),
    .tx_full       (tx_full),
    .tx_level      (tx_level),
    .tx            (tx),
    .tx_busy       (tx_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops and compares whenever the DUT shows a word at the RX FIFO head.
  initial begin
    logic [9:0] exp;
    forever begin
      @(negedge clk);
      rd_uart = 1'b0;
      if (mon_en && reset && !rx_empty) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rx_unexpected: got word 0x%0h, expected no word", 
                   {rx_frame_err, rx_parity_err, r_data});
        end else begin
          exp = exp_q.pop_front();
          check("rx_word", {22'd0, rx_frame_err, rx_parity_err, r_data}, {22'd0, exp});
        end
        rd_uart = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Drives one frame on rx; a bad stop bit returns high a quarter bit early so the
  // receiver's mid-bit sample still sees 0 but the trailing low is too short to start a frame.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic odd, input logic s2,
                            input logic bad_par, input logic stop_val);
    int bt;
    int st;
    bt = 16 * (int'(baud_div) + 1);
    st = s2 ? 2 * bt : bt;
    rx_drv = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (bt) @(negedge clk);
    end
    if (pe) begin
      rx_drv = (^d) ^ odd ^ bad_par;
      repeat (bt) @(negedge clk);
    end
    rx_drv = stop_val;
    repeat (stop_val ? st : st - bt / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (stop_val ? 2 * bt : 2 * bt + bt / 4) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !rx_empty || tx_busy || tx_level != 0) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(k < limit), 32'd1);
  endtask

  initial begin
    logic [9:0] frame_bits;
    logic [7:0] d;
    logic       pe, od, s2, bp, sv;
    int         busy_cnt;
    int         k;
    logic       found;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_level", 32'(rx_level), 32'd0);
    check("rst_tx_level", 32'(tx_level), 32'd0);
    check("rst_rx_overrun", 32'(rx_overrun), 32'd0);
    check("rst_flags", {30'd0, rx_frame_err, rx_parity_err}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // 8N1 waveform of 0xA5 at one tick per clock
    d = 8'hA5;
    frame_bits = {1'b1, d, 1'b0};
    wr_uart = 1'b1;
    w_data  = d;
    @(negedge clk);
    wr_uart = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (tx == 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    check("tx_start_seen", 32'(found), 32'd1);
    busy_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      if (tx_busy) busy_cnt++;
      if (c % 16 == 8 && c < 160) check($sformatf("tx_bit%0d", c / 16), 32'(tx),
                                         32'(frame_bits[c / 16]));
      @(negedge clk);
    end
    check("tx_busy_cycles", 32'(busy_cnt), 32'd160);

    // Directed RX: wrong even parity, bad stop bit, one-tick glitch
    parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b0;
    exp_q.push_back({1'b0, 1'b1, 8'h3C});
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    parity_en = 1'b0;
    d = 8'($urandom);
    exp_q.push_back({1'b1, 1'b0, d});
    send_frame(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    repeat (64) @(negedge clk);
    wait_drain("drain_directed", 2000);
    check("glitch_nothing_pushed", 32'(rx_level), 32'd0);

    // Random injected frames
    for (int f = 0; f < 16; f++) begin
      d  = 8'($urandom);
      pe = 1'($urandom);
      od = 1'($urandom);
      s2 = 1'($urandom);
      bp = pe & ($urandom_range(0, 3) == 0);
      sv = ($urandom_range(0, 4) != 0);
      baud_div = 11'($urandom_range(0, 1));
      parity_en = pe; parity_odd = od; stop2 = s2;
      exp_q.push_back({~sv, bp, d});
      send_frame(d, pe, od, s2, bp, sv);
    end
    wait_drain("drain_random", 2000);

    // Overrun: 17 frames with no reads
    baud_div = '0; parity_en = 1'b0; stop2 = 1'b0;
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    for (int f = 0; f < 17; f++) begin
      d = 8'($urandom);
      if (f < 16) exp_q.push_back({2'b00, d});
      send_frame(d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (f == 15) check("overrun_clear_at_16", 32'(rx_overrun), 32'd0);
    end
    check("overrun_level", 32'(rx_level), 32'd16);
    check("overrun_set", 32'(rx_overrun), 32'd1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("overrun_cleared", 32'(rx_overrun), 32'd0);
    mon_en = 1'b1;
    wait_drain("drain_overrun", 2000);

    // TX FIFO full: no tick for 2048 cycles after reset, so nothing is popped
    baud_div = 11'd2047;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom);
      if (i < 16) exp_q.push_back({2'b00, d});
      wr_uart = 1'b1;
      w_data  = d;
      @(negedge clk);
    end
    wr_uart = 1'b0;
    check("tx_full_set", 32'(tx_full), 32'd1);
    check("tx_full_level", 32'(tx_level), 32'd16);
    lb_en = 1'b1;
    baud_div = '0;
    wait_drain("drain_tx_full", 6000);

    // Loopback, odd parity, two stop bits, every byte value
    parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b1;
    for (int b = 0; b < 256; b++) begin
      k = 0;
      while (tx_full && k < 400) begin
        @(negedge clk);
        k++;
      end
      if (k >= 400) check("lb_tx_full_timeout", 32'(tx_full), 32'd0);
      wr_uart = 1'b1;
      w_data  = 8'(b);
      exp_q.push_back({2'b00, 8'(b)});
      @(negedge clk);
      wr_uart = 1'b0;
    end
    wait_drain("drain_loopback", 6000);

    // Reset in the middle of a data bit
    lb_en = 1'b0;
    parity_en = 1'b0; stop2 = 1'b0;
    wr_uart = 1'b1;
    w_data  = 8'h00;
    repeat (3) @(negedge clk);
    wr_uart = 1'b0;
    k = 0;
    while (!tx_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (40) @(negedge clk);
    check("tx_mid_data_low", 32'(tx), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(tx_busy), 32'd0);
    check("midrst_tx_level", 32'(tx_level), 32'd0);
    check("midrst_rx_level", 32'(rx_level), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    k = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx == 1'b0 || tx_busy) k++;
    end
    check("midrst_stays_idle", 32'(k), 32'd0);
    check("midrst_rx_empty", 32'(rx_empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
